// File: rtl/multibuffer_packer.sv
// Packs pairs of PKT_WIDTH packets into one queue word (slot 0 at bit 0, slot 1 at bit 64)
// behind a single-word output register; flush pads a lone staged packet with PAD_VALUE.
module multibuffer_packer #(
  parameter int                   Q_DATA_WIDTH = 128,
  parameter int                   PKT_WIDTH    = 42,
  parameter logic [PKT_WIDTH-1:0] PAD_VALUE    = {PKT_WIDTH{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [PKT_WIDTH-1:0]    in_data,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    write_en,
  output logic [Q_DATA_WIDTH-1:0] data_out,
  input  logic                    waitrequest,
  output logic                    busy,
  output logic [15:0]             pkt_count
);

  typedef enum logic {LO_EMPTY, LO_FULL} state_t;

  state_t                  state_q, state_d;
  logic [PKT_WIDTH-1:0]    lo_q, lo_d;
  logic                    out_valid_q, out_valid_d;
  logic [Q_DATA_WIDTH-1:0] data_q, data_d;
  logic                    flush_pending_q, flush_pending_d;
  logic [15:0]             pkt_count_q, pkt_count_d;

  logic out_free;
  logic flush_serve;
  logic accept;
  logic transfer;

  function automatic logic [Q_DATA_WIDTH-1:0] pack_word(input logic [PKT_WIDTH-1:0] slot0,
                                                        input logic [PKT_WIDTH-1:0] slot1);
    logic [Q_DATA_WIDTH-1:0] w;
    w = '0;
    w[PKT_WIDTH-1:0]   = slot0;
    w[64 +: PKT_WIDTH] = slot1;
    return w;
  endfunction

  // Output register can take a new word if empty or emptying this cycle.
  assign out_free    = !out_valid_q || !waitrequest;
  assign flush_serve = (state_q == LO_FULL) && flush_pending_q;
  assign in_ready    = !flush_serve && ((state_q == LO_EMPTY) || out_free);
  assign accept      = in_valid && in_ready;
  assign transfer    = out_valid_q && !waitrequest;

  always_comb begin
    state_d         = state_q;
    lo_d            = lo_q;
    out_valid_d     = transfer ? 1'b0 : out_valid_q;
    data_d          = data_q;
    flush_pending_d = flush_pending_q || flush;
    pkt_count_d     = pkt_count_q + 16'(accept);

    case (state_q)
      LO_EMPTY: begin
        if (accept) begin
          lo_d    = in_data;
          state_d = LO_FULL;
        end else if (flush_pending_q) begin
          // Nothing staged: the flush has nothing to pad.
          flush_pending_d = 1'b0;
        end
      end
      LO_FULL: begin
        if (flush_pending_q) begin
          if (out_free) begin
            data_d          = pack_word(lo_q, PAD_VALUE);
            out_valid_d     = 1'b1;
            state_d         = LO_EMPTY;
            flush_pending_d = 1'b0;
          end
        end else if (accept) begin
          data_d      = pack_word(lo_q, in_data);
          out_valid_d = 1'b1;
          state_d     = LO_EMPTY;
        end
      end
      default: state_d = LO_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LO_EMPTY;
      lo_q            <= '0;
      out_valid_q     <= 1'b0;
      data_q          <= '0;
      flush_pending_q <= 1'b0;
      pkt_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      lo_q            <= lo_d;
      out_valid_q     <= out_valid_d;
      data_q          <= data_d;
      flush_pending_q <= flush_pending_d;
      pkt_count_q     <= pkt_count_d;
    end
  end

  assign write_en  = out_valid_q;
  assign data_out  = data_q;
  assign busy      = (state_q == LO_FULL) || out_valid_q || flush_pending_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_multibuffer_packer.sv
// Directed bench for multibuffer_packer: a packet-queue model predicts every written word
// and the accepted-packet count; literal expectations pin key scenarios.
module tb_multibuffer_packer;
  localparam int QW = 128;
  localparam int PW = 42;
  localparam logic [PW-1:0] PAD = {PW{1'b1}};

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [PW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          write_en;
  logic [QW-1:0] data_out;
  logic          waitrequest;
  logic          busy;
  logic [15:0]   pkt_count;

  multibuffer_packer #(.Q_DATA_WIDTH(QW), .PKT_WIDTH(PW), .PAD_VALUE(PAD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .write_en(write_en), .data_out(data_out), .waitrequest(waitrequest),
    .busy(busy), .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [PW-1:0] pend[$];
  logic [QW-1:0] expq[$];
  int unsigned   mcnt = 0;
  bit            mflag = 0;
  bit            prev_stall = 0;
  logic [QW-1:0] prev_data;
  int            nwrites = 0;

  function automatic logic [QW-1:0] mk(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [QW-1:0] w;
    w = '0;
    w[PW-1:0]   = a;
    w[64 +: PW] = b;
    return w;
  endfunction

  always @(negedge clk) begin
    bit acc;
    bit trig;
    if (!rst_n) begin
      chk("we_in_reset", 128'(write_en), 128'(0));
      pend.delete();
      expq.delete();
      mcnt       = 0;
      mflag      = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_we", 128'(write_en), 128'(1));
        chk("stall_data", data_out, prev_data);
      end
      chk("pkt_count", 128'(pkt_count), 128'(mcnt[15:0]));
      if (write_en && !waitrequest) begin
        nwrites++;
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got %h, expected no write (t=%0t)", data_out, $time);
        end else begin
          chk("word", data_out, expq.pop_front());
        end
      end
      prev_stall = write_en && waitrequest;
      prev_data  = data_out;
      trig = flush || mflag;
      acc  = in_valid && in_ready;
      if (acc) begin
        pend.push_back(in_data);
        mcnt++;
        if (pend.size() == 2) begin
          expq.push_back(mk(pend[0], pend[1]));
          pend.delete();
        end
      end
      if (trig && pend.size() == 1) begin
        expq.push_back(mk(pend[0], PAD));
        pend.delete();
        mflag = 0;
      end else if (pend.size() == 0) begin
        // A flush seen with nothing staged lingers one cycle, then lapses unless a packet arrives.
        mflag = flush && !(mflag && !acc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic v, input logic [PW-1:0] d, input logic f);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    flush    = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_we", 128'(write_en), 128'(0));
  endtask

  task automatic wait_we(input string name);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (write_en) break;
    end
    if (i == 20) begin
      tests++;
      fails++;
      $display("FAIL %s: write_en never rose within 20 cycles, expected a write", name);
    end
  endtask

  int n0;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    waitrequest = 1'b0;
    #12;
    @(negedge clk);
    chk("async_reset_data", data_out, 128'(0));
    chk("async_reset_cnt", 128'(pkt_count), 128'(0));

    // Single pair, no backpressure
    do_reset();
    step(1'b1, 42'h1, 1'b0);
    step(1'b1, 42'h2, 1'b0);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("pair_latency_we", 128'(write_en), 128'(1));
    chk("pair_word", data_out, 128'h00000000000000020000000000000001);
    chk("pair_count", 128'(pkt_count), 128'(2));
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("pair_single_pulse", 128'(write_en), 128'(0));

    // Eight back-to-back packets
    do_reset();
    n0 = nwrites;
    for (int k = 0; k < 10; k++) begin
      step(k < 8, PW'(k + 16), 1'b0);
      @(negedge clk);
      if (k < 8) chk("thru_in_ready", 128'(in_ready), 128'(1));
      chk("thru_we", 128'(write_en), 128'((k >= 2) && (k <= 8) && (k % 2 == 0)));
    end
    chk("thru_writes", 128'(nwrites - n0), 128'(4));
    chk("thru_count", 128'(pkt_count), 128'(8));

    // Backpressure with a word pending and a third packet staged
    do_reset();
    n0 = nwrites;
    waitrequest = 1'b1;
    step(1'b1, 42'hA1, 1'b0);
    step(1'b1, 42'hB2, 1'b0);
    step(1'b1, 42'hC3, 1'b0);
    @(negedge clk);
    chk("bp_third_ready", 128'(in_ready), 128'(1));
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 42'hD4, 1'b0);
      @(negedge clk);
      chk("bp_fourth_blocked", 128'(in_ready), 128'(0));
      chk("bp_word_held", data_out, 128'h00000000000000B200000000000000A1);
    end
    @(posedge clk);
    #1;
    waitrequest = 1'b0;
    @(negedge clk);
    chk("bp_release_ready", 128'(in_ready), 128'(1));
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("bp_second_word", data_out, 128'h00000000000000D400000000000000C3);
    idle(3);
    chk("bp_writes", 128'(nwrites - n0), 128'(2));
    chk("bp_busy", 128'(busy), 128'(0));

    // Lone packet then flush pulse
    do_reset();
    n0 = nwrites;
    step(1'b1, 42'hABC, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    wait_we("flush_pad");
    chk("flush_pad_word", data_out, 128'h000003FFFFFFFFFF0000000000000ABC);
    idle(3);
    @(negedge clk);
    chk("flush_busy", 128'(busy), 128'(0));
    chk("flush_count", 128'(pkt_count), 128'(1));
    chk("flush_writes", 128'(nwrites - n0), 128'(1));

    // Flush with nothing staged
    do_reset();
    n0 = nwrites;
    step(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("idle_flush_we", 128'(write_en), 128'(0));
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("idle_flush_busy_set", 128'(busy), 128'(1));
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("idle_flush_busy_clear", 128'(busy), 128'(0));
    idle(3);
    chk("idle_flush_writes", 128'(nwrites - n0), 128'(0));

    // Flush coincident with the second packet: normal word only
    n0 = nwrites;
    step(1'b1, 42'h11, 1'b0);
    step(1'b1, 42'h22, 1'b1);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("coflush_word", data_out, 128'h00000000000000220000000000000011);
    idle(5);
    chk("coflush_writes", 128'(nwrites - n0), 128'(1));
    chk("coflush_busy", 128'(busy), 128'(0));

    // Reset while a stalled word is pending
    do_reset();
    waitrequest = 1'b1;
    step(1'b1, 42'h5, 1'b0);
    step(1'b1, 42'h6, 1'b0);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("rst_pre_we", 128'(write_en), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_we", 128'(write_en), 128'(0));
    chk("rst_async_cnt", 128'(pkt_count), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    waitrequest = 1'b0;
    rst_n = 1'b1;
    n0 = nwrites;
    idle(5);
    chk("rst_no_write", 128'(nwrites - n0), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));

    chk("model_drained", 128'(expq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
